// File: rtl/modexp_pkg.sv
// Shared types and codes for the modular-exponentiation scheduler.
// State enum, operand-select codes, destination codes, default key width.
package modexp_pkg;

  localparam int KEY_W_DEF = 1024;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONST,
    S_TO_MONT,
    S_INIT_X,
    S_SCAN,
    S_SQUARE,
    S_MULT,
    S_FROM_MONT,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_C   = 2'd0;
  localparam logic [1:0] SEL_X   = 2'd1;
  localparam logic [1:0] SEL_RT  = 2'd2;
  localparam logic [1:0] SEL_ONE = 2'd3;

  localparam logic DST_CBAR = 1'b0;
  localparam logic DST_X    = 1'b1;

endpackage

// File: rtl/modexp_exp_scan.sv
// Exponent shift register, bit index and leading-zero scan.
// MODEXP_SKIP_LZ_EN enables skipping leading zero bits in SCAN.
module modexp_exp_scan
  import modexp_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [KEY_W-1:0] exp_in,
  input  logic             scan,
  input  logic             step,
  output logic             bit_cur,
  output logic             idx_zero,
  output logic             scan_sq,
  output logic             scan_fm
);

  localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  logic [KEY_W-1:0] exp_q;
  logic [IW-1:0]    idx_q;
  logic             lz;
  logic             dec;

  assign bit_cur  = exp_q[KEY_W-1];
  assign idx_zero = (idx_q == '0);

`ifdef MODEXP_SKIP_LZ_EN
  assign lz      = scan & ~bit_cur & ~idx_zero;
  assign scan_sq = scan & bit_cur;
  assign scan_fm = scan & ~bit_cur & idx_zero;
`else
  assign lz      = 1'b0;
  assign scan_sq = scan;
  assign scan_fm = 1'b0;
`endif

  assign dec = step | lz;

  // MSB of the shift register is always the bit at the current index
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      exp_q <= exp_in;
      idx_q <= IW'(KEY_W - 1);
    end else if (dec) begin
      exp_q <= exp_q << 1;
      idx_q <= idx_q - IW'(1);
    end
  end

endmodule

// File: rtl/modexp_sched.sv
// Left-to-right square-and-multiply scheduler for a shared Montgomery
// multiplier. Optional leading-zero skip via MODEXP_SKIP_LZ_EN.
module modexp_sched
  import modexp_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] exp_in,
  output logic             busy,
  output logic             done,
  output logic             const_start,
  input  logic             const_done,
  output logic             mm_start,
  input  logic             mm_done,
  output logic [1:0]       mm_sel_a,
  output logic [1:0]       mm_sel_b,
  output logic             mm_dst,
  output logic [CNT_W-1:0] mm_cnt
);

  state_t     state_q, state_n;
  logic       fresh_q;
  logic       leave;
  logic       load;
  logic       step;
  logic       bit_cur;
  logic       idx_zero;
  logic       scan_sq;
  logic       scan_fm;
  logic       mm_ok;
  logic       const_ok;
  logic [CNT_W-1:0] cnt_q;

  // A completion in the same cycle as its own start pulse is not real
  assign mm_ok    = mm_done & ~fresh_q;
  assign const_ok = const_done & ~fresh_q;

  modexp_exp_scan #(
    .KEY_W(KEY_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .exp_in  (exp_in),
    .scan    (state_q == S_SCAN),
    .step    (step),
    .bit_cur (bit_cur),
    .idx_zero(idx_zero),
    .scan_sq (scan_sq),
    .scan_fm (scan_fm)
  );

  // State register; fresh marks the first cycle after any state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_n;
      fresh_q <= leave;
    end
  end

  // Multiply counter, cleared per job, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (mm_start && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    leave   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          leave   = 1'b1;
          state_n = S_CONST;
        end
      end
      S_CONST: begin
        if (const_ok) begin
          leave   = 1'b1;
          state_n = S_TO_MONT;
        end
      end
      S_TO_MONT: begin
        if (mm_ok) begin
          leave   = 1'b1;
          state_n = S_INIT_X;
        end
      end
      S_INIT_X: begin
        if (mm_ok) begin
          leave   = 1'b1;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_sq) begin
          leave   = 1'b1;
          state_n = S_SQUARE;
        end else if (scan_fm) begin
          leave   = 1'b1;
          state_n = S_FROM_MONT;
        end
      end
      S_SQUARE: begin
        if (mm_ok) begin
          leave = 1'b1;
          if (bit_cur) begin
            state_n = S_MULT;
          end else if (idx_zero) begin
            state_n = S_FROM_MONT;
          end else begin
            step    = 1'b1;
            state_n = S_SQUARE;
          end
        end
      end
      S_MULT: begin
        if (mm_ok) begin
          leave = 1'b1;
          if (idx_zero) begin
            state_n = S_FROM_MONT;
          end else begin
            step    = 1'b1;
            state_n = S_SQUARE;
          end
        end
      end
      S_FROM_MONT: begin
        if (mm_ok) begin
          leave   = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        leave   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    const_start = fresh_q & (state_q == S_CONST);
    mm_start    = 1'b0;
    mm_sel_a    = SEL_C;
    mm_sel_b    = SEL_C;
    mm_dst      = DST_CBAR;
    mm_cnt      = cnt_q;
    unique case (state_q)
      S_TO_MONT: begin
        mm_start = fresh_q;
        mm_sel_a = SEL_C;
        mm_sel_b = SEL_RT;
        mm_dst   = DST_CBAR;
      end
      S_INIT_X: begin
        mm_start = fresh_q;
        mm_sel_a = SEL_ONE;
        mm_sel_b = SEL_RT;
        mm_dst   = DST_X;
      end
      S_SQUARE: begin
        mm_start = fresh_q;
        mm_sel_a = SEL_X;
        mm_sel_b = SEL_X;
        mm_dst   = DST_X;
      end
      S_MULT: begin
        mm_start = fresh_q;
        mm_sel_a = SEL_X;
        mm_sel_b = SEL_C;
        mm_dst   = DST_X;
      end
      S_FROM_MONT: begin
        mm_start = fresh_q;
        mm_sel_a = SEL_X;
        mm_sel_b = SEL_ONE;
        mm_dst   = DST_X;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_modexp_sched.sv
// Scoreboard bench for modexp_sched with KEY_W=8.
// Multiplier and constant-unit models answer 3 cycles after start.
module tb_modexp_sched;

  localparam int KW = 8;
  localparam int CW = 16;

  localparam logic [5:0] OP_CONST = 6'b1_00_00_0;
  localparam logic [5:0] OP_TO    = 6'b0_00_10_0;
  localparam logic [5:0] OP_INIT  = 6'b0_11_10_1;
  localparam logic [5:0] OP_SQ    = 6'b0_01_01_1;
  localparam logic [5:0] OP_MUL   = 6'b0_01_00_1;
  localparam logic [5:0] OP_FM    = 6'b0_01_11_1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] exp_in;
  logic          busy, done;
  logic          const_start, const_done;
  logic          mm_start, mm_done;
  logic [1:0]    mm_sel_a, mm_sel_b;
  logic          mm_dst;
  logic [CW-1:0] mm_cnt;

  int total = 0;
  int bad = 0;
  bit skip;

  logic [5:0] exp_q[$];
  logic [5:0] cur;
  logic [5:0] e_op;
  logic [4:0] held;
  logic       pend = 1'b0;
  logic       cpend = 1'b0;
  logic       prev_start = 1'b0;
  int         n_mm = 0;
  int         n_done = 0;

  int   mm_cd = 0;
  int   c_cd = 0;
  logic mm_done_m = 1'b0;
  logic c_done_m = 1'b0;
  logic inj = 1'b0;
  logic coinc = 1'b0;

  assign mm_done    = mm_done_m | inj | (coinc & mm_start);
  assign const_done = c_done_m | (coinc & const_start);

  always #5 clk = ~clk;

  modexp_sched #(
    .KEY_W(KW),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .exp_in     (exp_in),
    .busy       (busy),
    .done       (done),
    .const_start(const_start),
    .const_done (const_done),
    .mm_start   (mm_start),
    .mm_done    (mm_done),
    .mm_sel_a   (mm_sel_a),
    .mm_sel_b   (mm_sel_b),
    .mm_dst     (mm_dst),
    .mm_cnt     (mm_cnt)
  );

  // Multiplier and constant-unit models
  always @(posedge clk) begin
    mm_done_m <= 1'b0;
    c_done_m  <= 1'b0;
    if (rst) begin
      mm_cd <= 0;
      c_cd  <= 0;
    end else begin
      if (mm_cd != 0) begin
        mm_cd <= mm_cd - 1;
        if (mm_cd == 1) mm_done_m <= 1'b1;
      end
      if (c_cd != 0) begin
        c_cd <= c_cd - 1;
        if (c_cd == 1) c_done_m <= 1'b1;
      end
      if (mm_start) mm_cd <= 3;
      if (const_start) c_cd <= 3;
    end
  end

  // Operation monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      cpend = 1'b0;
      prev_start = 1'b0;
      exp_q.delete();
    end else begin
      if (const_start) begin
        total++;
        e_op = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
        if (e_op !== OP_CONST) begin
          bad++;
          $display("FAIL op_seq: got const, expected op %b", e_op);
        end
        cpend = 1'b1;
      end else if (cpend && const_done) begin
        cpend = 1'b0;
      end
      if (mm_start) begin
        cur = {1'b0, mm_sel_a, mm_sel_b, mm_dst};
        total++;
        if (prev_start || pend || cpend) begin
          bad++;
          $display("FAIL mm_start_early: prev=%b pend=%b cpend=%b",
                   prev_start, pend, cpend);
        end
        total++;
        e_op = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
        if (cur !== e_op) begin
          bad++;
          $display("FAIL op_seq: got %b expected %b", cur, e_op);
        end
        pend = 1'b1;
        held = cur[4:0];
        n_mm++;
      end else if (pend) begin
        total++;
        if ({mm_sel_a, mm_sel_b, mm_dst} !== held) begin
          bad++;
          $display("FAIL sel_hold: got %b expected %b",
                   {mm_sel_a, mm_sel_b, mm_dst}, held);
        end
        if (mm_done) pend = 1'b0;
      end
      if (done) n_done++;
      prev_start = mm_start;
    end
  end

  task automatic push_job(input logic [KW-1:0] e, output int ec);
    int h;
    int n0;
    n0 = exp_q.size();
    exp_q.push_back(OP_CONST);
    exp_q.push_back(OP_TO);
    exp_q.push_back(OP_INIT);
    h = -1;
    if (skip) begin
      for (int i = KW - 1; i >= 0; i--) begin
        if (e[i] && h < 0) h = i;
      end
    end else begin
      h = KW - 1;
    end
    for (int i = h; i >= 0; i--) begin
      exp_q.push_back(OP_SQ);
      if (e[i]) exp_q.push_back(OP_MUL);
    end
    exp_q.push_back(OP_FM);
    ec = exp_q.size() - n0 - 1;
  endtask

  task automatic kick(input logic [KW-1:0] e, output int ec,
                      output int d0, output int base);
    push_job(e, ec);
    @(posedge clk);
    #1;
    d0 = n_done;
    base = n_mm;
    start = 1'b1;
    exp_in = e;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_job(input string name, input int ec,
                            input int d0, input bit tail);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: done never seen", name);
    end else begin
      total++;
      if (mm_cnt !== CW'(ec)) begin
        bad++;
        $display("FAIL %s_mm_cnt: got %0d expected %0d", name, mm_cnt, ec);
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL %s_ops_left: got %0d expected 0", name, exp_q.size());
      end
    end
    if (tail) begin
      repeat (4) @(negedge clk);
      total++;
      if (n_done - d0 != 1) begin
        bad++;
        $display("FAIL %s_done_cnt: got %0d expected 1", name, n_done - d0);
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL %s_idle: busy=%b expected 0", name, busy);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if ({busy, done, const_start, mm_start} !== 4'b0000) begin
      bad++;
      $display("FAIL %s_ctl: got %b expected 0000", name,
               {busy, done, const_start, mm_start});
    end
    total++;
    if ({mm_sel_a, mm_sel_b, mm_dst} !== 5'b0) begin
      bad++;
      $display("FAIL %s_sel: got %b expected 00000", name,
               {mm_sel_a, mm_sel_b, mm_dst});
    end
    total++;
    if (mm_cnt !== '0) begin
      bad++;
      $display("FAIL %s_cnt: got %0d expected 0", name, mm_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int ec, d0, b;
    kick(8'h05, ec, d0, b);
    finish_job("basic05", ec, d0, 1'b1);
  endtask

  task automatic test_zero();
    int ec, d0, b;
    kick(8'h00, ec, d0, b);
    finish_job("zero", ec, d0, 1'b1);
  endtask

  task automatic test_busy_ignore();
    int ec, d0, b;
    bit hit;
    kick(8'hFF, ec, d0, b);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (mm_done_m && n_mm == b + 2) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL ignore_init_x: not reached, mm=%0d", n_mm - b);
    end
    @(posedge clk);
    #1;
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (n_mm >= b + 5) hit = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    exp_in = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_job("ignoreFF", ec, d0, 1'b1);
  endtask

  task automatic test_coincident();
    int ec, d0, b;
    coinc = 1'b1;
    kick(8'h05, ec, d0, b);
    finish_job("coinc", ec, d0, 1'b1);
    coinc = 1'b0;
  endtask

  task automatic test_mid_reset();
    int ec, d0, b;
    bit hit;
    kick(8'h05, ec, d0, b);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (n_mm == b + 3) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL midrst_third: not reached, mm=%0d", n_mm - b);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (10) @(negedge clk);
    total++;
    if (n_done != d0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_nodone: done=%0d busy=%b expected 0 0",
               n_done - d0, busy);
    end
    kick(8'h05, ec, d0, b);
    finish_job("after_rst", ec, d0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int ec, d0, b;
    kick(8'hA3, ec, d0, b);
    finish_job("b2b_a", ec, d0, 1'b0);
    kick(8'h80, ec, d0, b);
    finish_job("b2b_b", ec, d0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    exp_in = '0;
`ifdef MODEXP_SKIP_LZ_EN
    skip = 1'b1;
`else
    skip = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero();
    test_busy_ignore();
    test_coincident();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modexp_sched.md
MODEXP_SCHED -- requirements
Module: modexp_sched

Interface
REQ-001 SHALL have parameter KEY_W, default 1024: modulus/exponent width in bits.
REQ-002 SHALL have parameter CNT_W, default 16: width of mm_cnt.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request; sampled only in IDLE.
REQ-006 SHALL have port exp_in  in  KEY_W  private exponent d; latched on accepted start.
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port const_start  out  1  one-cycle pulse to the r/r^2-mod-n constant unit.
REQ-010 SHALL have port const_done  in  1  constant unit finished (R_t = r^2 mod n valid).
REQ-011 SHALL have port mm_start  out  1  one-cycle pulse to the shared Montgomery multiplier.
REQ-012 SHALL have port mm_done  in  1  multiplier result valid.
REQ-013 SHALL have ports mm_sel_a / mm_sel_b  out  2 each  operand select: 0=C (ciphertext), 1=X (accumulator), 2=R_t, 3=literal one.
REQ-014 SHALL have port mm_dst  out  1  result destination: 0=Cbar register, 1=X register.
REQ-015 SHALL have port mm_cnt  out  CNT_W  count of mm_start pulses issued this job.

Function
REQ-016 SHALL implement states IDLE, CONST, TO_MONT, INIT_X, SCAN, SQUARE, MULT, FROM_MONT, DONE.
REQ-017 IDLE: start=1 latches exp_in, clears mm_cnt, sets bit index to KEY_W-1, goes to CONST.
REQ-018 CONST: pulse const_start in the first cycle; wait for const_done; then TO_MONT.
REQ-019 TO_MONT issues mm(C, R_t)->Cbar; INIT_X issues mm(one, R_t)->X.
REQ-020 SCAN: with leading-zero skip active, decrement index while the bit is 0; on the first 1 bit go to SQUARE; if all bits are 0, go to FROM_MONT.
REQ-021 SQUARE issues mm(X, X)->X; then MULT if the current bit is 1, else advance.
REQ-022 MULT issues mm(X, Cbar)->X, then advances.
REQ-023 Advance: if index==0 go to FROM_MONT, else decrement index and go to SQUARE.
REQ-024 FROM_MONT issues mm(X, one)->X, then DONE.
REQ-025 Each multiply state SHALL drive mm_start high for exactly its first cycle, hold mm_sel_a/mm_sel_b/mm_dst stable until mm_done, and leave only on mm_done=1.
REQ-026 mm_cnt SHALL increment on each mm_start pulse and saturate at all-ones.
REQ-027 DONE SHALL assert done for one cycle, then return to IDLE; minimum latency from mm_done of FROM_MONT to done is one cycle.
REQ-028 start while busy SHALL be ignored; const_done or mm_done outside its wait state SHALL be ignored.
REQ-029 const_done or mm_done coincident with its own start pulse SHALL be ignored; only a later cycle completes the operation.

Reset
REQ-030 rst SHALL force IDLE regardless of state, including mid-operation, and abandon the current job without pulsing done.
REQ-031 Reset values SHALL be: busy=0, done=0, const_start=0, mm_start=0, mm_sel_a=0, mm_sel_b=0, mm_dst=0, mm_cnt=0, and the latched exponent and index cleared.

Configuration
REQ-032 With macro MODEXP_SKIP_LZ_EN defined, SCAN SHALL skip leading zero bits at one bit per cycle, issuing no multiply.
REQ-033 Without MODEXP_SKIP_LZ_EN, SCAN SHALL go straight to SQUARE at index KEY_W-1 and process all KEY_W bits.

Structure
REQ-034 Package modexp_pkg SHALL hold the state enum, the operand-select codes (C/X/R_t/ONE), the destination codes and the KEY_W default.
REQ-035 Exponent shift register, index counter and leading-zero scan SHALL live in sub-module modexp_exp_scan; the FSM stays in modexp_sched.

Verification (bench KEY_W=8; multiplier and constant models answer 3 cycles after their start)
REQ-036 MODEXP_SKIP_LZ_EN on, exp_in=8'h05 -> operation sequence const, TO_MONT, INIT_X, SQ, MUL, SQ, SQ, MUL, FROM_MONT; mm_cnt=8 at done.
REQ-037 MODEXP_SKIP_LZ_EN off, exp_in=8'h05 -> 8 squares and 2 multiplies; mm_cnt=13 at done.
REQ-038 MODEXP_SKIP_LZ_EN on, exp_in=8'h00 -> TO_MONT, INIT_X, FROM_MONT only; mm_cnt=3; done pulses exactly once.
REQ-039 exp_in=8'hFF, start re-pulsed while busy and spurious mm_done injected in SCAN -> ignored; mm_cnt=19 with skip on.
REQ-040 rst=1 for one cycle during the third multiply wait -> next cycle all outputs at reset values, no done; a fresh start with 8'h05 completes normally.
REQ-041 Per operation: mm_sel_a/mm_sel_b/mm_dst match REQ-019..REQ-024, mm_start is exactly one cycle wide, and the selects hold until mm_done.
